// File: rtl/eth_pkg.sv
// Shared Ethernet constants: CRC-32 polynomial, initial state, good-frame residue,
// and the byte-swap used to present the FCS in wire order.
package eth_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    function automatic logic [31:0] bswap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

endpackage

// File: rtl/crc32_byte_step.sv
// Combinational next-state for a reflected CRC-32: absorbs one byte, LSB first,
// as eight unrolled LFSR shifts.
module crc32_byte_step
    import eth_pkg::*;
#(
    parameter logic [31:0] POLY = CRC32_POLY
) (
    input  logic [31:0] s_in,
    input  logic [7:0]  data,
    output logic [31:0] s_out
);

    logic [31:0] s_work;

    always_comb begin
        s_work = s_in;
        for (int i = 0; i < 8; i++) begin
            s_work = (s_work >> 1) ^ ((s_work[0] ^ data[i]) ? POLY : 32'h0);
        end
        s_out = s_work;
    end

endmodule

// File: rtl/eth_crc32.sv
// Byte-serial Ethernet FCS generator/checker: running CRC-32 state with the FCS
// presented in wire order and a residue match flag.
module eth_crc32
    import eth_pkg::*;
#(
    parameter logic [31:0] POLY    = CRC32_POLY,
    parameter logic [31:0] INIT    = CRC32_INIT,
    parameter logic [31:0] RESIDUE = CRC32_RESIDUE
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        vld,
    input  logic [7:0]  data,
    output logic [31:0] crc,
    output logic        good
);

    logic [31:0] s_q;
    logic [31:0] s_d;

    crc32_byte_step #(
        .POLY (POLY)
    ) u_step (
        .s_in  (s_q),
        .data  (data),
        .s_out (s_d)
    );

    // Reset has priority over a coincident valid byte.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s_q <= INIT;
        end else if (vld) begin
            s_q <= s_d;
        end
    end

    // Complemented state, byte-swapped so crc[31:24] is the first FCS byte sent.
    assign crc  = bswap32(~s_q);
    assign good = (s_q == RESIDUE);

endmodule

// File: tb/tb_eth_crc32.sv
// Self-checking bench for eth_crc32 against an MSB-first software CRC-32 model
// fed with bit-reversed bytes.
module tb_eth_crc32;

    logic        clk;
    logic        rstn;
    logic        vld;
    logic [7:0]  data;
    logic [31:0] crc;
    logic        good;

    int tests;
    int fails;

    logic [7:0] chk_str [9];

    eth_crc32 dut (
        .clk  (clk),
        .rstn (rstn),
        .vld  (vld),
        .data (data),
        .crc  (crc),
        .good (good)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Normal-form CRC-32 register (poly 0x04C11DB7), fed bit-reversed bytes.
    function automatic logic [31:0] ref_step(input logic [31:0] r, input logic [7:0] b);
        logic [7:0] rb;
        for (int i = 0; i < 8; i++) rb[i] = b[7-i];
        r = r ^ {rb, 24'h0};
        for (int k = 0; k < 8; k++) begin
            r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
        end
        return r;
    endfunction

    // Standard CRC-32 value, then laid out with its first wire byte in [31:24].
    function automatic logic [31:0] ref_fcs(input logic [31:0] r);
        logic [31:0] rr;
        logic [31:0] std_crc;
        for (int i = 0; i < 32; i++) rr[i] = r[31-i];
        std_crc = ~rr;
        return {std_crc[7:0], std_crc[15:8], std_crc[23:16], std_crc[31:24]};
    endfunction

    function automatic logic ref_good(input logic [31:0] r);
        return r == 32'hC704DD7B;
    endfunction

    // Inputs change on the falling edge; outputs are read on the next falling edge.
    task automatic cyc(input logic r, input logic v, input logic [7:0] d);
        rstn = r;
        vld  = v;
        data = d;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] first;
        cyc(1'b0, 1'b0, 8'h00);
        tests++;
        if (crc !== 32'h0) begin
            fails++;
            $display("FAIL reset_crc: got %h expected %h", crc, 32'h0);
        end
        tests++;
        if (good !== 1'b0) begin
            fails++;
            $display("FAIL reset_good: got %b expected 0", good);
        end
        first = crc;
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 8'($urandom));
        tests++;
        if (crc !== 32'h0) begin
            fails++;
            $display("FAIL idle_hold: got %h expected %h", crc, 32'h0);
        end
    endtask

    task automatic test_check_string();
        logic [31:0] r;
        r = 32'hFFFFFFFF;
        cyc(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, 1'b1, chk_str[i]);
            r = ref_step(r, chk_str[i]);
            tests++;
            if (crc !== ref_fcs(r)) begin
                fails++;
                $display("FAIL check_byte%0d: got %h expected %h", i, crc, ref_fcs(r));
            end
        end
        tests++;
        if (crc !== 32'h2639F4CB) begin
            fails++;
            $display("FAIL check_string: got %h expected %h", crc, 32'h2639F4CB);
        end
    endtask

    task automatic test_single_and_gaps();
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 8'h00);
        tests++;
        if (crc !== 32'h8DEF02D2) begin
            fails++;
            $display("FAIL single_zero: got %h expected %h", crc, 32'h8DEF02D2);
        end
        cyc(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, 1'b1, chk_str[i]);
            for (int g = 0; g < 3; g++) cyc(1'b1, 1'b0, 8'($urandom));
        end
        tests++;
        if (crc !== 32'h2639F4CB) begin
            fails++;
            $display("FAIL gapped_string: got %h expected %h", crc, 32'h2639F4CB);
        end
    endtask

    task automatic test_good();
        logic [31:0] fcs;
        for (int b = -1; b < 32; b++) begin
            fcs = 32'h2639F4CB;
            if (b >= 0) fcs = fcs ^ (32'h1 << b);
            cyc(1'b0, 1'b0, 8'h00);
            for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1, chk_str[i]);
            for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, fcs[31-8*k -: 8]);
            tests++;
            if (good !== (b < 0)) begin
                fails++;
                $display("FAIL good_flip%0d: got %b expected %b", b, good, (b < 0));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        cyc(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 8'($urandom));
        cyc(1'b0, 1'b1, 8'hA5);
        tests++;
        if (crc !== 32'h0 || good !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: got crc %h good %b expected crc 00000000 good 0",
                     crc, good);
        end
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1, chk_str[i]);
        tests++;
        if (crc !== 32'h2639F4CB) begin
            fails++;
            $display("FAIL mid_reset_restart: got %h expected %h", crc, 32'h2639F4CB);
        end
    endtask

    task automatic test_random_frames();
        logic [31:0] r;
        logic [31:0] fcs;
        logic [7:0]  b;
        int          len;
        int          bad;
        for (int f = 0; f < 4; f++) begin
            len = int'($urandom_range(60, 1514));
            r   = 32'hFFFFFFFF;
            bad = 0;
            cyc(1'b0, 1'b0, 8'h00);
            for (int i = 0; i < len + 4; i++) begin
                if (f[0] && $urandom_range(0, 3) == 0) cyc(1'b1, 1'b0, 8'($urandom));
                b = (i < len) ? 8'($urandom) : fcs[31-8*(i-len) -: 8];
                if (i == len) fcs = ref_fcs(r);
                if (i >= len) b = fcs[31-8*(i-len) -: 8];
                cyc(1'b1, 1'b1, b);
                r = ref_step(r, b);
                tests++;
                if (crc !== ref_fcs(r) || good !== ref_good(r)) begin
                    fails++;
                    if (bad < 5) begin
                        $display("FAIL rand_f%0d_b%0d: got crc %h good %b expected crc %h good %b",
                                 f, i, crc, good, ref_fcs(r), ref_good(r));
                    end
                    bad++;
                end
            end
            tests++;
            if (good !== 1'b1) begin
                fails++;
                $display("FAIL rand_f%0d_good: got %b expected 1", f, good);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        chk_str = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        rstn = 1'b0;
        vld  = 1'b0;
        data = 8'h00;
        @(negedge clk);
        test_reset();
        test_check_string();
        test_single_and_gaps();
        test_good();
        test_reset_mid_frame();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
